// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
// Holds the default widths, the controller state encoding and the port indices.
package dmem_ctrl_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    localparam int PORT_CPU = 0;
    localparam int PORT_LDR = 1;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter.
// On a tie the requester that was not served last wins; history only moves on an accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant[1];
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single RAM port between the CPU (port 0) and the program loader (port 1),
// with registered read responses and a bulk-clear sequencer that sweeps every word.
module dmem_port_arbiter
    import dmem_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              cpu_hold,
    input  logic              init_start,
    output logic              init_busy,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_d,
    output logic [ADDR_W-1:0] mem_dpra,
    input  logic [DATA_W-1:0] mem_dpo
);

    state_t                   state, state_nxt;
    logic [ADDR_W-1:0]        clr_cnt;
    logic                     clr_last;
    logic [1:0]               pv, pwe, req, grant;
    logic [1:0][ADDR_W-1:0]   paddr;
    logic [1:0][DATA_W-1:0]   pwdata, rdata_q;
    logic [1:0]               rvalid_q;
    logic                     sel;

    assign pv     = {p1_valid, p0_valid & ~cpu_hold};
    assign pwe    = {p1_we, p0_we};
    assign paddr  = {p1_addr, p0_addr};
    assign pwdata = {p1_wdata, p0_wdata};

    // No requests reach the arbiter while clearing, so readys stay low there.
    assign req = (state == ST_ARB) ? pv : 2'b00;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (|grant),
        .grant  (grant)
    );

    assign p0_ready  = grant[PORT_CPU];
    assign p1_ready  = grant[PORT_LDR];
    assign sel       = grant[PORT_LDR];
    assign clr_last  = &clr_cnt;
    assign init_busy = (state == ST_CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_ARB;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARB:   if (init_start) state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_last)   state_nxt = ST_ARB;
            default:  state_nxt = ST_ARB;
        endcase
    end

    always_comb begin
        mem_a    = '0;
        mem_dpra = '0;
        mem_d    = '0;
        mem_we   = 1'b0;
        if (state == ST_CLEAR) begin
            mem_a  = clr_cnt;
            mem_d  = INIT_VALUE;
            mem_we = 1'b1;
        end else if (|grant) begin
            mem_a    = paddr[sel];
            mem_dpra = paddr[sel];
            mem_d    = pwdata[sel];
            mem_we   = pwe[sel];
        end
    end

    // Counter wraps to zero on the last clear write, ready for the next sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            if (state == ST_CLEAR)
                clr_cnt <= clr_cnt + ADDR_W'(1);
            init_done <= (state == ST_CLEAR) && clr_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rvalid_q[i] <= grant[i] & ~pwe[i];
                if (grant[i] & ~pwe[i])
                    rdata_q[i] <= mem_dpo;
            end
        end
    end

    assign p0_rvalid = rvalid_q[PORT_CPU];
    assign p1_rvalid = rvalid_q[PORT_LDR];
    assign p0_rdata  = rdata_q[PORT_CPU];
    assign p1_rdata  = rdata_q[PORT_LDR];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed bench for dmem_port_arbiter with a RAM model, a spec-level
// reference model feeding response queues, and an independent response monitor.
module tb_dmem_port_arbiter;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_valid = 1'b0, p0_we = 1'b0, p1_valid = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          cpu_hold = 1'b0, init_start = 1'b0;
    logic          init_busy, init_done, mem_we;
    logic [AW-1:0] mem_a, mem_dpra;
    logic [DW-1:0] mem_d, mem_dpo;

    dmem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .cpu_hold(cpu_hold), .init_start(init_start), .init_busy(init_busy),
        .init_done(init_done), .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d),
        .mem_dpra(mem_dpra), .mem_dpo(mem_dpo)
    );

    always #5 clk = ~clk;

    // Physical RAM: combinational read, write on the clock edge.
    logic [DW-1:0] ram [DEPTH];
    assign mem_dpo = ram[mem_dpra];
    always @(posedge clk) if (mem_we) ram[mem_a] <= mem_d;

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
    typedef struct { int due; logic [DW-1:0] data; } rsp_t;
    req_t sq0[$], sq1[$];
    rsp_t rq0[$], rq1[$];

    logic [DW-1:0] ref_mem [DEPTH];
    int  ncmp = 0, nbad = 0, cyc = 0;
    int  m_last = 1, m_clr = 0;
    bit  m_done = 0, acc0 = 0, acc1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: evaluates the arbitration rules on the inputs held for the coming edge.
    always @(negedge clk) begin
        int win;
        if (rst) begin
            chk("rst p0_ready", 32'(p0_ready), 0);
            chk("rst p1_ready", 32'(p1_ready), 0);
            chk("rst rvalid", 32'({p1_rvalid, p0_rvalid}), 0);
            chk("rst busy/done", 32'({init_busy, init_done}), 0);
            chk("rst mem_we", 32'(mem_we), 0);
            chk("rst p0_rdata", p0_rdata, 0);
            chk("rst p1_rdata", p1_rdata, 0);
            rq0.delete(); rq1.delete();
            m_last = 1; m_clr = 0; m_done = 0;
        end else if (m_clr > 0) begin
            chk("clr init_busy", 32'(init_busy), 1);
            chk("clr init_done", 32'(init_done), 0);
            chk("clr readys", 32'({p1_ready, p0_ready}), 0);
            chk("clr mem_we", 32'(mem_we), 1);
            chk("clr mem_a", 32'(mem_a), 32'(DEPTH - m_clr));
            chk("clr mem_d", mem_d, 0);
            ref_mem[DEPTH - m_clr] = '0;
            m_clr--;
            if (m_clr == 0) m_done = 1;
        end else begin
            chk("arb init_busy", 32'(init_busy), 0);
            chk("arb init_done", 32'(init_done), 32'(m_done));
            m_done = 0;
            win = -1;
            if (p0_valid && !cpu_hold && p1_valid) win = 1 - m_last;
            else if (p0_valid && !cpu_hold)        win = 0;
            else if (p1_valid)                     win = 1;
            chk("p0_ready", 32'(p0_ready), 32'(win == 0));
            chk("p1_ready", 32'(p1_ready), 32'(win == 1));
            if (win == 0) begin
                chk("p0 mem_we", 32'(mem_we), 32'(p0_we));
                chk("p0 mem_a", 32'(mem_a), 32'(p0_addr));
                if (p0_we) begin
                    chk("p0 mem_d", mem_d, p0_wdata);
                    ref_mem[p0_addr] = p0_wdata;
                end else begin
                    chk("p0 mem_dpra", 32'(mem_dpra), 32'(p0_addr));
                    rq0.push_back('{cyc + 1, ref_mem[p0_addr]});
                end
                m_last = 0;
            end else if (win == 1) begin
                chk("p1 mem_we", 32'(mem_we), 32'(p1_we));
                chk("p1 mem_a", 32'(mem_a), 32'(p1_addr));
                if (p1_we) begin
                    chk("p1 mem_d", mem_d, p1_wdata);
                    ref_mem[p1_addr] = p1_wdata;
                end else begin
                    chk("p1 mem_dpra", 32'(mem_dpra), 32'(p1_addr));
                    rq1.push_back('{cyc + 1, ref_mem[p1_addr]});
                end
                m_last = 1;
            end else begin
                chk("idle mem_we", 32'(mem_we), 0);
            end
            if (init_start) m_clr = DEPTH;
        end
    end

    // Monitor: matches each rvalid pulse against the oldest expected response.
    always @(negedge clk) begin
        rsp_t r;
        if (!rst) begin
            if (p0_rvalid) begin
                if (rq0.size() == 0 || rq0[0].due != cyc) chk("p0_rvalid unexpected", 1, 0);
                else begin r = rq0.pop_front(); chk("p0_rdata", p0_rdata, r.data); end
            end else if (rq0.size() != 0 && rq0[0].due <= cyc) begin
                chk("p0_rvalid missing", 0, 1); void'(rq0.pop_front());
            end
            if (p1_rvalid) begin
                if (rq1.size() == 0 || rq1[0].due != cyc) chk("p1_rvalid unexpected", 1, 0);
                else begin r = rq1.pop_front(); chk("p1_rdata", p1_rdata, r.data); end
            end else if (rq1.size() != 0 && rq1[0].due <= cyc) begin
                chk("p1_rvalid missing", 0, 1); void'(rq1.pop_front());
            end
        end
    end

    // Request driver: holds a request until it is accepted, then loads the next one.
    always @(negedge clk) begin
        acc0 = p0_valid & p0_ready;
        acc1 = p1_valid & p1_ready;
    end

    always @(posedge clk) begin
        req_t r;
        #1;
        if (!p0_valid || acc0) begin
            if (sq0.size() != 0) begin
                r = sq0.pop_front();
                p0_valid = 1'b1; p0_we = r.we; p0_addr = r.addr; p0_wdata = r.wdata;
            end else p0_valid = 1'b0;
        end
        if (!p1_valid || acc1) begin
            if (sq1.size() != 0) begin
                r = sq1.pop_front();
                p1_valid = 1'b1; p1_we = r.we; p1_addr = r.addr; p1_wdata = r.wdata;
            end else p1_valid = 1'b0;
        end
        acc0 = 0; acc1 = 0;
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #3;
            if (sq0.size() == 0 && sq1.size() == 0 && !p0_valid && !p1_valid &&
                rq0.size() == 0 && rq1.size() == 0) begin ok = 1; break; end
        end
        chk("drain timeout", 32'(ok), 1);
    endtask

    task automatic wait_clear_end();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!init_busy) begin ok = 1; break; end
        end
        chk("clear timeout", 32'(ok), 1);
    endtask

    task automatic pulse_init();
        init_start = 1'b1; tick(); init_start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            ram[i] = v; ref_mem[i] = v;
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        tick();

        // Write then immediate read of the same word.
        sq0.push_back('{1'b1, 11'd5, 32'hDEADBEEF});
        sq0.push_back('{1'b0, 11'd5, 32'h0});
        wait_idle(50);

        // Both ports streaming reads: grants alternate.
        for (int i = 0; i < 4; i++) begin
            sq0.push_back('{1'b0, AW'($urandom_range(0, 63)), 32'h0});
            sq1.push_back('{1'b0, AW'($urandom_range(0, 63)), 32'h0});
        end
        wait_idle(50);

        // CPU held off while the loader runs.
        cpu_hold = 1'b1;
        for (int i = 0; i < 4; i++) sq1.push_back('{1'b0, AW'(100 + i), 32'h0});
        sq0.push_back('{1'b0, 11'd5, 32'h0});
        repeat (6) tick();
        cpu_hold = 1'b0;
        wait_idle(50);

        // Bulk clear over previously written boundary words, with a restart attempt mid-sweep.
        sq1.push_back('{1'b1, 11'd0, 32'h1234});
        sq1.push_back('{1'b1, 11'd2047, 32'h1234});
        wait_idle(50);
        pulse_init();
        sq0.push_back('{1'b0, 11'd7, 32'h0});
        repeat (500) tick();
        pulse_init();
        wait_clear_end();
        sq1.push_back('{1'b0, 11'd0, 32'h0});
        sq1.push_back('{1'b0, 11'd2047, 32'h0});
        wait_idle(100);

        // Clear requested in the same cycle as an accepted loader read.
        sq1.push_back('{1'b1, 11'd9, 32'hA5A5_0009});
        wait_idle(50);
        sq1.push_back('{1'b0, 11'd9, 32'h0});
        @(posedge clk); #2 init_start = 1'b1;
        tick(); init_start = 1'b0;
        wait_clear_end();
        wait_idle(50);

        // Reset part way through a clear.
        sq0.push_back('{1'b1, 11'd1500, 32'hCAFEF00D});
        wait_idle(50);
        pulse_init();
        repeat (100) tick();
        rst = 1'b1;
        #1 chk("abort init_busy", 32'(init_busy), 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        sq0.push_back('{1'b0, 11'd1500, 32'h0});
        sq0.push_back('{1'b0, 11'd50, 32'h0});
        wait_idle(50);

        // Random traffic with intermittent CPU hold.
        for (int i = 0; i < 400; i++) begin
            tick();
            cpu_hold = ($urandom_range(0, 7) == 0);
            if (sq0.size() < 2 && $urandom_range(0, 1) == 1)
                sq0.push_back('{1'($urandom), AW'($urandom_range(0, 15)), 32'($urandom)});
            if (sq1.size() < 2 && $urandom_range(0, 1) == 1)
                sq1.push_back('{1'($urandom), AW'($urandom_range(0, 15)), 32'($urandom)});
        end
        cpu_hold = 1'b0;
        wait_idle(200);

        chk("pending responses", 32'(rq0.size() + rq1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
